// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a shared single-port 16-bit memory.
// Each access holds the memory for LAT cycles; contention alternates between ports.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LAT        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [15:0]           i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic [15:0]           d_rdata,
    output logic                  d_done,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic                  busy
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
    localparam logic ONE_CYC = (LAT == 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    sel_data_q;
    logic                    last_data_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       i_rdata_q;
    logic [DATA_W-1:0]       d_rdata_q;
    logic                    en_q;
    logic                    wr_pulse_q;
    logic                    i_done_q;
    logic                    d_done_q;
    logic                    pick_data_c;

    // D wins when alone, or when both request and I was served last.
    assign pick_data_c = d_req && (!i_req || !last_data_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            en_q        <= 1'b0;
            wr_pulse_q  <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        state_q     <= S_BUSY;
                        cnt_q       <= CNT_INIT;
                        sel_data_q  <= pick_data_c;
                        last_data_q <= pick_data_c;
                        en_q        <= 1'b1;
                        wdata_q     <= d_wdata;
                        addr_q      <= (pick_data_c ? d_addr : i_addr) & ALIGN_MASK;
                        wr_q        <= pick_data_c & d_wr;
                        wr_pulse_q  <= pick_data_c & d_wr & ONE_CYC;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_DONE;
                        en_q       <= 1'b0;
                        wr_pulse_q <= 1'b0;
                        if (!wr_q) begin
                            if (sel_data_q) d_rdata_q <= mem_rdata;
                            else            i_rdata_q <= mem_rdata;
                        end
                        if (sel_data_q) d_done_q <= 1'b1;
                        else            i_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        // Arm the write strobe so it lands on the last BUSY cycle only.
                        if (cnt_q == CNT_W'(1)) wr_pulse_q <= wr_q;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Control strobes are squashed in any cycle rst is high, aborting a pending write.
    assign mem_en    = en_q & ~rst;
    assign mem_wr    = wr_pulse_q & ~rst;
    assign i_done    = i_done_q & ~rst;
    assign d_done    = d_done_q & ~rst;
    assign busy      = (state_q != S_IDLE) && !rst;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed latency/arbitration/reset scenarios plus a
// randomized run against a transaction-timing reference model with a shadow memory.
module tb_mem_arbiter;

    localparam int unsigned AW  = 16;
    localparam int unsigned LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_wr;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [15:0]   d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_done, d_done, mem_en, mem_wr, busy;

    logic [15:0]   mem    [0:255];
    logic [15:0]   shadow [0:255];
    logic          pre_we;
    logic [7:0]    pre_idx;
    logic [15:0]   pre_data;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Word-addressed memory with combinational read; backdoor preload port for setup.
    assign mem_rdata = mem[mem_addr[8:1]];
    always @(posedge clk) begin
        if (pre_we)                mem[pre_idx] <= pre_data;
        else if (mem_en && mem_wr) mem[mem_addr[8:1]] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [15:0] data);
        pre_idx = idx; pre_data = data; pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
        shadow[idx] = data;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b1;
        i_addr = 16'h0010; d_addr = 16'h0020; d_wdata = 16'hFFFF;
        tick(); tick(); tick();
        @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (mem_en !== 1'b0)  begin errors++; $display("FAIL rst_mem_en got %b exp 0", mem_en); end
        checks++; if (mem_wr !== 1'b0)  begin errors++; $display("FAIL rst_mem_wr got %b exp 0", mem_wr); end
        checks++; if (i_done !== 1'b0)  begin errors++; $display("FAIL rst_i_done got %b exp 0", i_done); end
        checks++; if (d_done !== 1'b0)  begin errors++; $display("FAIL rst_d_done got %b exp 0", d_done); end
        checks++; if (i_rdata !== 16'h0) begin errors++; $display("FAIL rst_i_rdata got %h exp 0000", i_rdata); end
        checks++; if (d_rdata !== 16'h0) begin errors++; $display("FAIL rst_d_rdata got %h exp 0000", d_rdata); end
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_write();
        logic e;
        apply_reset();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234;
        for (int c = 1; c <= 8; c++) begin
            if (c == 7) idle_inputs();
            @(negedge clk);
            e = (c >= 2 && c <= 5);
            checks++; if (mem_en !== e) begin errors++; $display("FAIL wr_mem_en cyc %0d got %b exp %b", c, mem_en, e); end
            e = (c == 5);
            checks++; if (mem_wr !== e) begin errors++; $display("FAIL wr_mem_wr cyc %0d got %b exp %b", c, mem_wr, e); end
            e = (c == 6);
            checks++; if (d_done !== e) begin errors++; $display("FAIL wr_d_done cyc %0d got %b exp %b", c, d_done, e); end
            checks++; if (i_done !== 1'b0) begin errors++; $display("FAIL wr_i_done cyc %0d got %b exp 0", c, i_done); end
            e = (c >= 2 && c <= 6);
            checks++; if (busy !== e) begin errors++; $display("FAIL wr_busy cyc %0d got %b exp %b", c, busy, e); end
            if (c == 2) begin
                checks++; if (mem_addr !== 16'h0010)  begin errors++; $display("FAIL wr_addr got %h exp 0010", mem_addr); end
                checks++; if (mem_wdata !== 16'h1234) begin errors++; $display("FAIL wr_wdata got %h exp 1234", mem_wdata); end
            end
            if (c == 6) begin
                checks++; if (d_rdata !== 16'h0) begin errors++; $display("FAIL wr_d_rdata got %h exp 0000", d_rdata); end
            end
            tick();
        end
        checks++; if (mem[8] !== 16'h1234) begin errors++; $display("FAIL wr_mem_word got %h exp 1234", mem[8]); end
    endtask

    task automatic test_read_after_write();
        logic e;
        i_req = 1'b1; i_addr = 16'h0010;
        for (int c = 1; c <= 8; c++) begin
            if (c == 7) idle_inputs();
            @(negedge clk);
            e = (c == 6);
            checks++; if (i_done !== e)    begin errors++; $display("FAIL rd_i_done cyc %0d got %b exp %b", c, i_done, e); end
            checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL rd_d_done cyc %0d got %b exp 0", c, d_done); end
            checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rd_mem_wr cyc %0d got %b exp 0", c, mem_wr); end
            if (c == 6) begin
                checks++; if (i_rdata !== 16'h1234) begin errors++; $display("FAIL rd_i_rdata got %h exp 1234", i_rdata); end
                checks++; if (d_rdata !== 16'h0000) begin errors++; $display("FAIL rd_d_rdata got %h exp 0000", d_rdata); end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        logic e;
        preload(8'h10, 16'hBEEF);
        preload(8'h18, 16'h5A5A);
        apply_reset();
        i_req = 1'b1; i_addr = 16'h0030;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
        for (int c = 1; c <= 14; c++) begin
            if (c == 7)  d_req = 1'b0;
            if (c == 13) idle_inputs();
            @(negedge clk);
            e = (c == 6);
            checks++; if (d_done !== e) begin errors++; $display("FAIL ct_d_done cyc %0d got %b exp %b", c, d_done, e); end
            e = (c == 12);
            checks++; if (i_done !== e) begin errors++; $display("FAIL ct_i_done cyc %0d got %b exp %b", c, i_done, e); end
            if (c == 2) begin
                checks++; if (mem_addr !== 16'h0020) begin errors++; $display("FAIL ct_first_addr got %h exp 0020", mem_addr); end
            end
            if (c == 7) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ct_idle7 got %b exp 0", busy); end
            end
            if (c == 8) begin
                checks++; if (mem_addr !== 16'h0030) begin errors++; $display("FAIL ct_second_addr got %h exp 0030", mem_addr); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ct_busy8 got %b exp 1", busy); end
            end
            if (c == 6) begin
                checks++; if (d_rdata !== 16'hBEEF) begin errors++; $display("FAIL ct_d_rdata got %h exp beef", d_rdata); end
            end
            if (c == 12) begin
                checks++; if (i_rdata !== 16'h5A5A) begin errors++; $display("FAIL ct_i_rdata got %h exp 5a5a", i_rdata); end
            end
            tick();
        end
    endtask

    task automatic test_alternate();
        int kinds[$];
        int dcyc[$];
        int exp_kind;
        preload(8'h20, 16'h1111);
        preload(8'h28, 16'h2222);
        apply_reset();
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0050;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            checks++; if (i_done && d_done) begin errors++; $display("FAIL alt_both_done cyc %0d got 1 exp 0", c); end
            if (d_done) begin kinds.push_back(1); dcyc.push_back(c); end
            if (i_done) begin kinds.push_back(0); dcyc.push_back(c); end
            tick();
        end
        idle_inputs();
        repeat (LAT + 3) tick();
        checks++; if (kinds.size() < 4) begin errors++; $display("FAIL alt_count got %0d exp >=4", kinds.size()); end
        if (kinds.size() > 0) begin
            checks++; if (dcyc[0] != 6) begin errors++; $display("FAIL alt_first_done got %0d exp 6", dcyc[0]); end
        end
        for (int k = 0; k < 4; k++) begin
            if (k < kinds.size()) begin
                exp_kind = (k % 2 == 0) ? 1 : 0;
                checks++; if (kinds[k] != exp_kind) begin errors++; $display("FAIL alt_order idx %0d got %0d exp %0d", k, kinds[k], exp_kind); end
            end
        end
        for (int k = 1; k < kinds.size(); k++) begin
            checks++; if (dcyc[k] - dcyc[k-1] > int'(LAT) + 2) begin errors++; $display("FAIL alt_gap idx %0d got %0d exp <=%0d", k, dcyc[k] - dcyc[k-1], LAT + 2); end
        end
        checks++; if (d_rdata !== 16'h2222) begin errors++; $display("FAIL alt_d_rdata got %h exp 2222", d_rdata); end
        checks++; if (i_rdata !== 16'h1111) begin errors++; $display("FAIL alt_i_rdata got %h exp 1111", i_rdata); end
    endtask

    task automatic test_reset_abort();
        logic e;
        preload(8'h08, 16'hAAAA);
        apply_reset();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) rst = 1'b1;
            if (c == 4) begin rst = 1'b0; idle_inputs(); end
            @(negedge clk);
            checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL ab_mem_wr cyc %0d got %b exp 0", c, mem_wr); end
            checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL ab_d_done cyc %0d got %b exp 0", c, d_done); end
            e = (c == 2);
            checks++; if (mem_en !== e) begin errors++; $display("FAIL ab_mem_en cyc %0d got %b exp %b", c, mem_en, e); end
            if (c >= 3) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy cyc %0d got %b exp 0", c, busy); end
            end
            tick();
        end
        checks++; if (mem[8] !== 16'hAAAA)  begin errors++; $display("FAIL ab_mem_word got %h exp aaaa", mem[8]); end
        checks++; if (d_rdata !== 16'h0000) begin errors++; $display("FAIL ab_d_rdata got %h exp 0000", d_rdata); end
    endtask

    task automatic test_addr_align();
        logic e;
        preload(8'h08, 16'h7777);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0011;
        for (int c = 1; c <= 8; c++) begin
            if (c == 7) idle_inputs();
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL al_addr cyc %0d got %h exp 0010", c, mem_addr); end
                checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL al_en cyc %0d got %b exp 1", c, mem_en); end
            end
            e = (c == 6);
            checks++; if (d_done !== e) begin errors++; $display("FAIL al_d_done cyc %0d got %b exp %b", c, d_done, e); end
            if (c == 6) begin
                checks++; if (d_rdata !== 16'h7777) begin errors++; $display("FAIL al_d_rdata got %h exp 7777", d_rdata); end
            end
            tick();
        end
    endtask

    // Reference model: one transaction at a time, timed from its grant cycle g.
    task automatic test_random();
        logic        i_pend = 1'b0, d_pend = 1'b0, act = 1'b0, last_d = 1'b0;
        logic        g_d = 1'b0, g_wr = 1'b0;
        int          g = 0;
        logic [15:0] g_addr = '0, g_wdata = '0, g_rexp = '0;
        logic [15:0] exp_i_rd = '0, exp_d_rd = '0;
        logic        e_en, e_wr, e_idone, e_ddone, e_busy;
        for (int k = 0; k < 16; k++) preload(8'(k), 16'($urandom));
        apply_reset();
        for (int t = 1; t <= 600; t++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1; i_req = 1'b1; i_addr = 16'($urandom_range(0, 31));
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1; d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
                d_addr = 16'($urandom_range(0, 31)); d_wdata = 16'($urandom);
            end
            if (act && t > g && t <= g + int'(LAT) && $urandom_range(0, 3) == 0) begin
                if (g_d) begin
                    d_req = 1'b0; d_wr = 1'($urandom_range(0, 1));
                    d_addr = 16'($urandom); d_wdata = 16'($urandom);
                end else begin
                    i_req = 1'b0; i_addr = 16'($urandom);
                end
            end
            if ((!act || t >= g + int'(LAT) + 2) && (i_req || d_req)) begin
                act     = 1'b1;
                g       = t;
                g_d     = d_req && (!i_req || !last_d);
                last_d  = g_d;
                g_addr  = g_d ? d_addr : i_addr;
                g_wr    = g_d && d_wr;
                g_wdata = d_wdata;
                g_rexp  = shadow[g_addr[8:1]];
                if (g_wr) shadow[g_addr[8:1]] = g_wdata;
            end
            e_en    = act && t > g && t <= g + int'(LAT);
            e_wr    = e_en && g_wr && t == g + int'(LAT);
            e_ddone = act && g_d && t == g + int'(LAT) + 1;
            e_idone = act && !g_d && t == g + int'(LAT) + 1;
            e_busy  = act && t > g && t <= g + int'(LAT) + 1;
            if (e_ddone && !g_wr) exp_d_rd = g_rexp;
            if (e_idone)          exp_i_rd = g_rexp;
            @(negedge clk);
            checks++; if (mem_en !== e_en)     begin errors++; $display("FAIL rnd_mem_en t %0d got %b exp %b", t, mem_en, e_en); end
            checks++; if (mem_wr !== e_wr)     begin errors++; $display("FAIL rnd_mem_wr t %0d got %b exp %b", t, mem_wr, e_wr); end
            checks++; if (d_done !== e_ddone)  begin errors++; $display("FAIL rnd_d_done t %0d got %b exp %b", t, d_done, e_ddone); end
            checks++; if (i_done !== e_idone)  begin errors++; $display("FAIL rnd_i_done t %0d got %b exp %b", t, i_done, e_idone); end
            checks++; if (busy !== e_busy)     begin errors++; $display("FAIL rnd_busy t %0d got %b exp %b", t, busy, e_busy); end
            checks++; if (d_rdata !== exp_d_rd) begin errors++; $display("FAIL rnd_d_rdata t %0d got %h exp %h", t, d_rdata, exp_d_rd); end
            checks++; if (i_rdata !== exp_i_rd) begin errors++; $display("FAIL rnd_i_rdata t %0d got %h exp %h", t, i_rdata, exp_i_rd); end
            if (e_en) begin
                checks++; if (mem_addr !== (g_addr & 16'hFFFE)) begin errors++; $display("FAIL rnd_addr t %0d got %h exp %h", t, mem_addr, g_addr & 16'hFFFE); end
                checks++; if (mem_wdata !== g_wdata) begin errors++; $display("FAIL rnd_wdata t %0d got %h exp %h", t, mem_wdata, g_wdata); end
            end
            if (e_ddone) begin d_pend = 1'b0; d_req = 1'b0; end
            if (e_idone) begin i_pend = 1'b0; i_req = 1'b0; end
            tick();
        end
        idle_inputs();
        repeat (LAT + 3) tick();
        for (int k = 0; k < 16; k++) begin
            checks++; if (mem[k] !== shadow[k]) begin errors++; $display("FAIL rnd_mem idx %0d got %h exp %h", k, mem[k], shadow[k]); end
        end
    endtask

    initial begin
        pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_read_after_write();
        test_contention();
        test_alternate();
        test_reset_abort();
        test_addr_align();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the width of every address port.
REQ-002 The block SHALL have parameter LAT, default 4, meaning the number of cycles mem_en is held per access (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit, clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 The block SHALL have port i_req, input, 1 bit, instruction-side read request.
REQ-006 The block SHALL have port i_addr, input, ADDR_WIDTH bits, instruction-side byte address.
REQ-007 The block SHALL have port i_rdata, output, 16 bits, instruction-side read data.
REQ-008 The block SHALL have port i_done, output, 1 bit, one-cycle instruction completion pulse.
REQ-009 The block SHALL have ports d_req, d_wr (1 bit each), d_addr (ADDR_WIDTH bits) and d_wdata (16 bits), all inputs: data-side request, write flag, byte address and write data.
REQ-010 The block SHALL have port d_rdata, output, 16 bits, data-side read data.
REQ-011 The block SHALL have port d_done, output, 1 bit, one-cycle data-side completion pulse.
REQ-012 The block SHALL have ports mem_en, mem_wr (1 bit each), mem_addr (ADDR_WIDTH bits) and mem_wdata (16 bits), all outputs, driving the shared single-port memory.
REQ-013 The block SHALL have port mem_rdata, input, 16 bits, the memory's combinational read data.
REQ-014 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement three states, IDLE, BUSY and DONE, with a cycle counter of at least 4 bits.
REQ-016 In IDLE with any request high, the block SHALL latch the granted port, address, wr flag (0 for I) and wdata, then enter BUSY with counter = LAT-1.
REQ-017 Arbitration SHALL work as follows: if only one request is high, that port is granted; if both are high, the port not granted last time is granted; last_grant resets to I, so D wins the first contest.
REQ-018 In BUSY, mem_en SHALL be 1 and mem_addr SHALL be the latched address with bit 0 forced to 0.
REQ-019 mem_wdata SHALL equal the latched data.
REQ-020 In BUSY, the counter SHALL decrement each cycle; at counter = 0 the next state SHALL be DONE.
REQ-021 mem_wr SHALL be 1 only in the final BUSY cycle (counter = 0) of a write, gated by ~rst, so exactly one write edge reaches the memory per write.
REQ-022 For a read, mem_rdata SHALL be captured into the granted port's rdata register at the final BUSY cycle; a write SHALL leave both rdata registers unchanged.
REQ-023 In DONE, the granted port's done output SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-024 Latency SHALL be: request sampled in IDLE at cycle t, BUSY during t+1..t+LAT, done at t+LAT+1, IDLE at t+LAT+2.
REQ-025 Requesters SHALL hold req and their inputs until done; a request still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-026 Deassertion of req or changes to the inputs during BUSY SHALL be ignored; the latched transaction always completes.
REQ-027 Outside BUSY, mem_en and mem_wr SHALL be 0; i_done and d_done SHALL never be high in the same cycle.
REQ-028 i_rdata and d_rdata SHALL hold their value until the next read completion on the same port.

Reset
REQ-029 On a cycle with rst high, the next state SHALL be IDLE, the counter 0, last_grant = I, and i_rdata and d_rdata 0x0000.
REQ-030 While in reset, i_done, d_done, mem_en, mem_wr and busy SHALL all be 0.
REQ-031 rst asserted during BUSY SHALL abort the transaction: no write edge, no done pulse, and no rdata update.

Verification (LAT=4, reset released before cycle 1)
REQ-032 The bench SHALL cover: d_req, d_wr=1, d_addr=0x0010, d_wdata=0x1234 at cycle 1 -> mem_en high in cycles 2-5, mem_wr high in cycle 5 only, d_done in cycle 6.
REQ-033 The bench SHALL cover: an I read of 0x0010 after that write -> i_done pulse with i_rdata=0x1234, and d_rdata unchanged.
REQ-034 The bench SHALL cover: i_req and d_req (a read) both high at cycle 1 -> d_done at cycle 6, I granted at cycle 7, i_done at cycle 12.
REQ-035 The bench SHALL cover: d_req held continuously with i_req pending -> grants alternate D, I, D, I; no done gap exceeds LAT+2 cycles.
REQ-036 The bench SHALL cover: rst high in cycle 3 of the cycle-1 write -> IDLE at cycle 4, no mem_wr pulse, no d_done, and memory at 0x0010 unchanged.
REQ-037 The bench SHALL cover: a D read at d_addr=0x0011 -> mem_addr=0x0010 throughout BUSY.
